// File: rtl/bus_write_router_if.sv
// Pipeline write-bus bundle. The pipeline is the master and the router is the slave.
interface bus_write_router_if;
    logic [31:0] bus_addr;
    logic [31:0] bus_dout;
    logic        bus_write_valid;
    logic        bus_write_ready;

    modport master (
        output bus_addr,
        output bus_dout,
        output bus_write_valid,
        input  bus_write_ready
    );

    modport slave (
        input  bus_addr,
        input  bus_dout,
        input  bus_write_valid,
        output bus_write_ready
    );
endinterface

// File: rtl/bus_write_router.sv
// Routes pipeline writes into per-channel FIFOs for write-only peripherals.
// Writes to nonexistent channels in the device region are dropped and counted.
module bus_write_router #(
    parameter int          N_CH    = 2,
    parameter int          DATA_W  = 8,
    parameter int          DEPTH   = 4,
    parameter int          TAG_LO  = 4,
    parameter logic [31:0] TAG     = 28'hFFF_FFFF,
    parameter int          SEL_LSB = 2,
    parameter int          SEL_W   = 2,
    parameter int          ERR_W   = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    bus_write_router_if.slave                   bus,
    output logic [N_CH-1:0]                     dev_valid,
    output logic [N_CH*DATA_W-1:0]              dev_data,
    input  logic [N_CH-1:0]                     dev_ready,
    output logic [N_CH*($clog2(DEPTH)+1)-1:0]   dev_level,
    input  logic                                err_clr,
    output logic [ERR_W-1:0]                    err_count,
    output logic                                err_sticky
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic             hit;
    logic [SEL_W-1:0] ch;
    logic             mapped;
    logic             unmapped;
    logic [N_CH-1:0]  full;
    logic             full_sel;
    logic             accept;
    logic             unused_bits;

    assign hit      = (bus.bus_addr[31:TAG_LO] == TAG[31-TAG_LO:0]);
    assign ch       = bus.bus_addr[SEL_LSB +: SEL_W];
    assign mapped   = hit && (int'(ch) < N_CH);
    assign unmapped = hit && (int'(ch) >= N_CH);

    assign unused_bits = ^{bus.bus_addr, bus.bus_dout};

    // Index through a loop so an out-of-range channel never indexes past full[]
    always_comb begin
        full_sel = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch == SEL_W'(i)) full_sel = full[i];
        end
    end

    // Ready depends only on registered occupancy, never on dev_ready
    assign bus.bus_write_ready = !(mapped && full_sel);
    assign accept              = bus.bus_write_valid && bus.bus_write_ready;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [DATA_W-1:0] mem [DEPTH];
        logic [AW-1:0]     rd_ptr;
        logic [AW-1:0]     wr_ptr;
        logic [LW-1:0]     level;
        logic              push;
        logic              pop;

        assign push = accept && mapped && (ch == SEL_W'(i));
        assign pop  = (level != '0) && dev_ready[i];
        assign full[i] = (level == LW'(DEPTH));

        assign dev_valid[i]                   = (level != '0);
        assign dev_data[i*DATA_W +: DATA_W]   = mem[rd_ptr];
        assign dev_level[i*LW +: LW]          = level;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= bus.bus_dout[DATA_W-1:0];
                    wr_ptr      <= wr_ptr + AW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   level <= level + LW'(1);
                    2'b01:   level <= level - LW'(1);
                    default: level <= level;
                endcase
            end
        end
    end

    // Clear takes effect first so a concurrent unmapped write still registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else if (err_clr) begin
            err_count  <= (accept && unmapped) ? ERR_W'(1) : '0;
            err_sticky <= accept && unmapped;
        end else if (accept && unmapped) begin
            err_sticky <= 1'b1;
            if (err_count != '1) err_count <= err_count + ERR_W'(1);
        end
    end
endmodule
